irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-mode interrupt controller for the single-cycle RISC-V core.
- Sits between platform interrupt lines and the CSR controller.
- Latches requests, masks them with mie from the CSR controller, and picks one by fixed priority.
- Raises a one-cycle trap request with its mcause value, tracks handler occupancy (no nesting), and returns a one-hot acknowledge to the serviced source on mret.

Parameters:
- IRQ_NUM, 16, number of interrupt lines (1..16).
- IRQ_BASE, 16, cause code and mie bit index of line 0; line k uses mie bit IRQ_BASE+k.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous active-high reset.
- irq_req_i  input  IRQ_NUM  interrupt requests; synchronous to clk_i; the source holds each until acknowledged.
- mie_i  input  32  mie CSR value from the CSR controller.
- stall_i  input  1  core stalled (memory wait); a trap cannot be taken.
- exception_i  input  1  synchronous exception trap taken by the core this cycle.
- mret_i  input  1  mret executing this cycle.
- irq_o  output  1  interrupt trap request to the core (drives trap together with exception).
- irq_cause_o  output  32  mcause value for irq_o.
- irq_ret_o  output  IRQ_NUM  one-hot acknowledge to the serviced line.
- busy_o  output  1  trap handler active (state != IDLE).

Behaviour:
- All state updates on the rising edge of clk_i; reset is synchronous, active-high.
- Reset:
  - pend_q = 0, state = IDLE, active_q = 0.
  - Outputs: irq_o = 0, irq_cause_o = 0, irq_ret_o = 0, busy_o = 0.
- Pending register pend_q[IRQ_NUM-1:0] is sticky:
  - Each edge: pend_q[k] <= (pend_q[k] | irq_req_i[k]) & ~clr[k].
  - clr = irq_ret_o; clear wins over set on the same edge.
  - Bits latch regardless of mie_i.
- Eligible set: elig = pend_q & mie_i[IRQ_BASE+IRQ_NUM-1 : IRQ_BASE].
- Priority: lowest index wins. sel = index of the least significant set bit of elig.
- FSM states IDLE, IRQ, EXC:
  - IDLE, exception_i=1: go to EXC; irq_o = 0 (exception has precedence).
  - IDLE, exception_i=0, stall_i=0, elig != 0: irq_o = 1 (combinational, this cycle only); irq_cause_o = 32'h8000_0000 | (IRQ_BASE+sel); at the edge active_q <= sel and state goes to IRQ.
  - IDLE, stall_i=1: irq_o = 0; stay in IDLE; pending retained.
  - IRQ, mret_i=1: irq_ret_o = one-hot(active_q) this cycle; go to IDLE; pend_q[active_q] cleared at that edge.
  - EXC, mret_i=1: go to IDLE; irq_ret_o = 0.
  - IRQ or EXC, exception_i=1: ignored; state and active_q unchanged.
  - IDLE, mret_i=1: ignored; irq_ret_o = 0.
- Output defaults:
  - irq_cause_o = 0 whenever irq_o = 0.
  - irq_ret_o = 0 outside an IRQ-state mret.
  - busy_o = (state != IDLE), registered.
- Latency: a request sampled at edge E drives irq_o in the cycle after E, given IDLE, enabled and not stalled.
- Back-to-back: an interrupt can fire in the first IDLE cycle after mret (one cycle after the mret edge).
- Any line pending at the mret edge, other than the one being cleared, is eligible then.
- A request arriving while in IRQ or EXC is latched and serviced after mret.
- Clearing mie while pending: the line is held; it fires once re-enabled.
- Reset mid-service: FSM to IDLE, all pending requests lost, no irq_ret_o generated.
- Unused mie_i bits are ignored.

Test Plan:
1. Reset: assert rst_i 2 cycles with irq_req_i=16'hFFFF and mie_i=32'hFFFF_FFFF -> all outputs 0 during reset; first cycle after reset irq_o=0; the following cycle irq_o=1 with irq_cause_o=32'h8000_0010.
2. Single line: mie_i=32'h0008_0000, irq_req_i[3]=1 -> irq_o one cycle, irq_cause_o=32'h8000_0013, then busy_o=1. mret_i pulse -> irq_ret_o=16'h0008 that cycle, busy_o=0 next. Source drops the request -> no retrigger.
3. Priority: irq_req_i[5] and irq_req_i[2] together, mie_i=32'h0024_0000 -> cause 32'h8000_0012 first. After mret (ret=16'h0004), line 5 fires one cycle later with cause 32'h8000_0015.
4. Masking: irq_req_i[7]=1, mie_i=0 for 10 cycles -> irq_o stays 0. Set mie_i bit 23 -> irq_o the next cycle, cause 32'h8000_0017.
5. Exception precedence: exception_i=1 in the same cycle line 0 becomes eligible -> irq_o=0, busy_o=1. mret_i -> irq_ret_o=0; line 0 then fires, cause 32'h8000_0010.
6. Stall and reset mid-service:
   - stall_i=1 with line 1 eligible -> irq_o held 0; stall released -> irq_o=1.
   - Later, rst_i during IRQ state -> busy_o=0, pend_q=0, irq_ret_o never pulsed.

Source files
------------

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: sticky pending latch, mie masking,
// fixed lowest-index priority, single-level trap occupancy and mret acknowledge.
module irq_controller #(
   parameter int IRQ_NUM  = 16,
   parameter int IRQ_BASE = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   input  logic [31:0]        mie_i,
   input  logic               stall_i,
   input  logic               exception_i,
   input  logic               mret_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_ret_o,
   output logic               busy_o
);

   localparam int AW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] IRQ  = 2'd1;
   localparam logic [1:0] EXC  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IRQ_NUM-1:0] pend_q, pend_d;
   logic [AW-1:0]      active_q, active_d;
   logic [IRQ_NUM-1:0] elig;
   logic [AW-1:0]      sel;
   logic               take;
   logic               ret;

   assign elig = pend_q & mie_i[IRQ_BASE +: IRQ_NUM];

   // Scan downwards so the lowest set index is the last one assigned.
   always_comb begin
      sel = '0;
      for (int k = IRQ_NUM - 1; k >= 0; k--) begin
         if (elig[k]) sel = AW'(k);
      end
   end

   // Outputs are forced quiet while reset is held, even before state settles.
   assign take = (state_q == IDLE) & ~exception_i & ~stall_i & (|elig) & ~rst_i;
   assign ret  = (state_q == IRQ) & mret_i & ~rst_i;

   assign irq_o       = take;
   assign irq_cause_o = take ? (32'h8000_0000 | (32'(IRQ_BASE) + 32'(sel))) : 32'h0;
   assign irq_ret_o   = ret ? (IRQ_NUM'(1) << active_q) : '0;
   assign busy_o      = (state_q != IDLE);

   assign pend_d = (pend_q | irq_req_i) & ~irq_ret_o;

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      case (state_q)
         IDLE: begin
            if (exception_i) begin
               state_d = EXC;
            end else if (take) begin
               state_d  = IRQ;
               active_d = sel;
            end
         end
         IRQ:     if (mret_i) state_d = IDLE;
         EXC:     if (mret_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         active_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         active_q <= active_d;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected causes and acknowledges are
// queued as stimulus is applied and compared when the DUT presents them.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [15:0] irq_req_i;
   logic [31:0] mie_i;
   logic        stall_i, exception_i, mret_i;
   logic        irq_o;
   logic [31:0] irq_cause_o;
   logic [15:0] irq_ret_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] cause_q[$];
   logic [15:0] ret_q[$];
   logic [31:0] exp_c;
   logic [15:0] exp_r;

   irq_controller #(.IRQ_NUM(16), .IRQ_BASE(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .irq_req_i(irq_req_i), .mie_i(mie_i),
      .stall_i(stall_i), .exception_i(exception_i), .mret_i(mret_i),
      .irq_o(irq_o), .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; irq_req_i = '0; mie_i = '0;
      stall_i = 1'b0; exception_i = 1'b0; mret_i = 1'b0;
      cyc(); cyc();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; irq_req_i = 16'hFFFF; mie_i = 32'hFFFF_FFFF;
      stall_i = 1'b0; exception_i = 1'b0; mret_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc(); #1;
         checks++;
         if ({irq_o, irq_cause_o, irq_ret_o, busy_o} !== 50'h0) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: irq=%b cause=%h ret=%h busy=%b, want all 0",
                     i, irq_o, irq_cause_o, irq_ret_o, busy_o);
         end
      end
      rst_i = 1'b0;
      cause_q.push_back(32'h8000_0010);
      #1;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++; $display("FAIL reset_first_cycle: irq=%b want 0", irq_o);
      end
      cyc(); #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++;
         $display("FAIL reset_second_cycle: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
   endtask

   task automatic test_single();
      do_reset();
      mie_i = 32'h0008_0000; irq_req_i = 16'h0008;
      cause_q.push_back(32'h8000_0013); ret_q.push_back(16'h0008);
      cyc(); #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL single_irq: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); #1;
      checks++;
      if (irq_o !== 1'b0 || busy_o !== 1'b1 || irq_cause_o !== 32'h0) begin
         errors++; $display("FAIL single_busy: irq=%b busy=%b cause=%h want 0 1 0", irq_o, busy_o, irq_cause_o);
      end
      mret_i = 1'b1; irq_req_i = '0; #1;
      exp_r = ret_q.pop_front();
      checks++;
      if (irq_ret_o !== exp_r) begin
         errors++; $display("FAIL single_ret: ret=%h want %h", irq_ret_o, exp_r);
      end
      cyc(); mret_i = 1'b0; #1;
      checks++;
      if (busy_o !== 1'b0 || irq_ret_o !== 16'h0) begin
         errors++; $display("FAIL single_idle: busy=%b ret=%h want 0 0", busy_o, irq_ret_o);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         checks++;
         if (irq_o !== 1'b0) begin
            errors++; $display("FAIL single_no_retrigger cyc%0d: irq=%b want 0", i, irq_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mie_i = 32'h0024_0000; irq_req_i = 16'h0024;
      cause_q.push_back(32'h8000_0012); cause_q.push_back(32'h8000_0015);
      ret_q.push_back(16'h0004); ret_q.push_back(16'h0020);
      cyc(); #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL prio_first: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); mret_i = 1'b1; irq_req_i = 16'h0020; #1;
      exp_r = ret_q.pop_front();
      checks++;
      if (irq_ret_o !== exp_r) begin
         errors++; $display("FAIL prio_ret_first: ret=%h want %h", irq_ret_o, exp_r);
      end
      cyc(); mret_i = 1'b0; #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL prio_second: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); mret_i = 1'b1; irq_req_i = '0; #1;
      exp_r = ret_q.pop_front();
      checks++;
      if (irq_ret_o !== exp_r) begin
         errors++; $display("FAIL prio_ret_second: ret=%h want %h", irq_ret_o, exp_r);
      end
      cyc(); mret_i = 1'b0; #1;
      checks++;
      if (busy_o !== 1'b0 || irq_o !== 1'b0) begin
         errors++; $display("FAIL prio_drained: busy=%b irq=%b want 0 0", busy_o, irq_o);
      end
   endtask

   task automatic test_masking();
      do_reset();
      mie_i = 32'h0; irq_req_i = 16'h0080;
      for (int i = 0; i < 10; i++) begin
         cyc(); #1;
         checks++;
         if (irq_o !== 1'b0) begin
            errors++; $display("FAIL mask_held cyc%0d: irq=%b want 0", i, irq_o);
         end
      end
      // unrelated mie bits must not unmask line 7
      mie_i = 32'hFF7F_FFFF; #1;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++; $display("FAIL mask_other_bits: irq=%b want 0", irq_o);
      end
      cause_q.push_back(32'h8000_0017); ret_q.push_back(16'h0080);
      mie_i = 32'h0080_0000; #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL mask_enable: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); mret_i = 1'b1; irq_req_i = '0; #1;
      exp_r = ret_q.pop_front();
      checks++;
      if (irq_ret_o !== exp_r) begin
         errors++; $display("FAIL mask_ret: ret=%h want %h", irq_ret_o, exp_r);
      end
      cyc(); mret_i = 1'b0;
   endtask

   task automatic test_exception();
      do_reset();
      mie_i = 32'h0001_0000; irq_req_i = 16'h0001;
      cyc(); exception_i = 1'b1; #1;
      checks++;
      if (irq_o !== 1'b0 || irq_cause_o !== 32'h0) begin
         errors++; $display("FAIL exc_precedence: irq=%b cause=%h want 0 0", irq_o, irq_cause_o);
      end
      cyc(); exception_i = 1'b0; #1;
      checks++;
      if (busy_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++; $display("FAIL exc_busy: busy=%b irq=%b want 1 0", busy_o, irq_o);
      end
      cyc(); exception_i = 1'b1; #1;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL exc_nested_ignored: busy=%b want 1", busy_o);
      end
      cyc(); exception_i = 1'b0; mret_i = 1'b1; #1;
      checks++;
      if (irq_ret_o !== 16'h0) begin
         errors++; $display("FAIL exc_ret_zero: ret=%h want 0", irq_ret_o);
      end
      cause_q.push_back(32'h8000_0010); ret_q.push_back(16'h0001);
      cyc(); mret_i = 1'b0; #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL exc_then_irq: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); mret_i = 1'b1; irq_req_i = '0; #1;
      exp_r = ret_q.pop_front();
      checks++;
      if (irq_ret_o !== exp_r) begin
         errors++; $display("FAIL exc_irq_ret: ret=%h want %h", irq_ret_o, exp_r);
      end
      cyc(); mret_i = 1'b0;
   endtask

   task automatic test_stall_reset();
      do_reset();
      mie_i = 32'h0002_0000; stall_i = 1'b1; irq_req_i = 16'h0002;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         checks++;
         if (irq_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL stall_held cyc%0d: irq=%b busy=%b want 0 0", i, irq_o, busy_o);
         end
      end
      cause_q.push_back(32'h8000_0011);
      stall_i = 1'b0; #1;
      exp_c = cause_q.pop_front();
      checks++;
      if (irq_o !== 1'b1 || irq_cause_o !== exp_c) begin
         errors++; $display("FAIL stall_release: irq=%b cause=%h want 1 %h", irq_o, irq_cause_o, exp_c);
      end
      cyc(); #1;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL stall_busy: busy=%b want 1", busy_o);
      end
      rst_i = 1'b1; mret_i = 1'b1; irq_req_i = '0; #1;
      checks++;
      if (irq_ret_o !== 16'h0) begin
         errors++; $display("FAIL rst_no_ret: ret=%h want 0", irq_ret_o);
      end
      cyc(); rst_i = 1'b0; mret_i = 1'b0; #1;
      checks++;
      if (busy_o !== 1'b0 || dut.pend_q !== 16'h0) begin
         errors++; $display("FAIL rst_mid_service: busy=%b pend=%h want 0 0", busy_o, dut.pend_q);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         checks++;
         if (irq_o !== 1'b0 || irq_ret_o !== 16'h0) begin
            errors++; $display("FAIL rst_lost cyc%0d: irq=%b ret=%h want 0 0", i, irq_o, irq_ret_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_masking();
      test_exception();
      test_stall_reset();
      checks++;
      if (cause_q.size() != 0 || ret_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: cause_q=%0d ret_q=%0d want 0 0", cause_q.size(), ret_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
